// File: rtl/sorter_pkg.sv
// ============================================================================
//  Module   : sorter_pkg
//  Purpose  : Shared types and helpers for the param_sorter block: FSM state
//             encoding, fixed-latency formula and the element compare used by
//             the selection pass.
//  Revision : 1.0  initial parametrised release
// ============================================================================
`default_nettype none

package sorter_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    OUT_RD   = 3'd1,
    OUT_WAIT = 3'd2,
    IN_WAIT  = 3'd3,
    IN_CMP   = 3'd4,
    SWAP_A   = 3'd5,
    SWAP_B   = 3'd6
  } state_t;

  // Cycles from the start-accept edge to the edge that raises ready.
  function automatic int sort_latency(input int depth);
    return 4 * (depth - 1) + depth * (depth - 1);
  endfunction

  // Returns 1 when cand must replace best. Strict compare, so ties keep the
  // earlier index. Operands arrive zero-extended to 64 bits; for signed
  // operation the bits above width are refilled from the element sign bit.
  function automatic logic cmp_better(input logic [63:0] cand,
                                      input logic [63:0] best,
                                      input logic        desc,
                                      input logic        is_signed,
                                      input int          width);
    logic [63:0] c_x;
    logic [63:0] b_x;
    logic        lt;
    logic        gt;
    c_x = cand;
    b_x = best;
    if (is_signed) begin
      for (int k = 0; k < 64; k++) begin
        if (k >= width) begin
          c_x[k] = cand[width-1];
          b_x[k] = best[width-1];
        end
      end
      lt = $signed(c_x) < $signed(b_x);
      gt = $signed(c_x) > $signed(b_x);
    end else begin
      lt = c_x < b_x;
      gt = c_x > b_x;
    end
    return desc ? gt : lt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sorter_ram.sv
// ============================================================================
//  Module   : sorter_ram
//  Purpose  : DEPTH x DATA_W single-clock RAM, one write port and one
//             registered read port (read-before-write on a shared address).
//             The array has no reset.
//  Ports    : clk            clock
//             we/waddr/wdata write port
//             raddr          read address, sampled every edge
//             rdata          registered read data
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sorter_ram #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/param_sorter.sv
// ============================================================================
//  Module   : param_sorter
//  Purpose  : In-place selection sorter over an internal RAM. The host loads
//             data while ready=1, pulses start, waits for ready, reads back.
//  Ports    : clk, nrst (async active-low)
//             start, desc       begin sort / direction (latched on accept)
//             wr, addr, datain  host write / read address
//             dataout           host read data, 1-cycle latency
//             ready             1 = idle, host owns memory
//             swap_count        only with SORTER_SWAP_COUNT_EN defined
//  Options  : `define SORTER_SWAP_COUNT_EN adds the swap_count output.
//  Revision : 1.0  initial parametrised release
// ============================================================================
`default_nettype none

module param_sorter
  import sorter_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 8,
  parameter  int SIGNED = 0,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              desc,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout,
`ifdef SORTER_SWAP_COUNT_EN
  output logic [ADDR_W-1:0] swap_count,
`endif
  output logic              ready
);

  localparam logic [ADDR_W-1:0] C_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] C_LAST   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] C_LAST_I = ADDR_W'(DEPTH - 2);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_i, w_i_nxt;
  logic [ADDR_W-1:0] r_j, w_j_nxt;
  logic [ADDR_W-1:0] r_best_idx, w_best_idx_nxt;
  logic [DATA_W-1:0] r_best, w_best_nxt;
  logic [DATA_W-1:0] r_cur, w_cur_nxt;
  logic [DATA_W-1:0] r_hold, w_hold_nxt;
  logic              r_desc, w_desc_nxt;
  logic              r_host_sel, w_host_sel_nxt;
  logic              w_accept;
  logic              w_better;

  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_waddr;
  logic [DATA_W-1:0] w_ram_wdata;
  logic [ADDR_W-1:0] w_ram_raddr;
  logic [DATA_W-1:0] w_ram_rdata;

  sorter_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .waddr (w_ram_waddr),
    .wdata (w_ram_wdata),
    .raddr (w_ram_raddr),
    .rdata (w_ram_rdata)
  );

  assign w_better = cmp_better(64'(w_ram_rdata), 64'(r_best), r_desc,
                               SIGNED != 0, DATA_W);

  // The RAM read register is shared with the FSM. While r_host_sel is set it
  // holds the last host read; otherwise r_hold carries the value dataout had
  // when the sort was accepted (or 0 after reset), so dataout never moves
  // while busy.
  assign dataout = r_host_sel ? w_ram_rdata : r_hold;
  assign ready   = (r_state == IDLE);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= IDLE;
      r_i        <= '0;
      r_j        <= '0;
      r_best_idx <= '0;
      r_best     <= '0;
      r_cur      <= '0;
      r_hold     <= '0;
      r_desc     <= 1'b0;
      r_host_sel <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_i        <= w_i_nxt;
      r_j        <= w_j_nxt;
      r_best_idx <= w_best_idx_nxt;
      r_best     <= w_best_nxt;
      r_cur      <= w_cur_nxt;
      r_hold     <= w_hold_nxt;
      r_desc     <= w_desc_nxt;
      r_host_sel <= w_host_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_i_nxt        = r_i;
    w_j_nxt        = r_j;
    w_best_idx_nxt = r_best_idx;
    w_best_nxt     = r_best;
    w_cur_nxt      = r_cur;
    w_hold_nxt     = r_hold;
    w_desc_nxt     = r_desc;
    w_host_sel_nxt = r_host_sel;
    w_accept       = 1'b0;
    w_ram_we       = 1'b0;
    w_ram_waddr    = addr;
    w_ram_wdata    = datain;
    w_ram_raddr    = addr;

    case (r_state)
      IDLE: begin
        if (start) begin
          // start wins over a same-cycle write, which is dropped
          w_accept       = 1'b1;
          w_desc_nxt     = desc;
          w_i_nxt        = '0;
          w_hold_nxt     = dataout;
          w_host_sel_nxt = 1'b0;
          w_state_nxt    = OUT_RD;
        end else begin
          // reads every idle cycle; a same-address write returns old data
          w_ram_we       = wr;
          w_host_sel_nxt = 1'b1;
        end
      end
      OUT_RD: begin
        w_ram_raddr = r_i;
        w_state_nxt = OUT_WAIT;
      end
      OUT_WAIT: begin
        w_best_nxt     = w_ram_rdata;
        w_cur_nxt      = w_ram_rdata;
        w_best_idx_nxt = r_i;
        w_j_nxt        = r_i + C_ONE;
        w_ram_raddr    = r_i + C_ONE;
        w_state_nxt    = IN_WAIT;
      end
      IN_WAIT: begin
        // re-issuing the same address keeps mem[j] on the read register
        w_ram_raddr = r_j;
        w_state_nxt = IN_CMP;
      end
      IN_CMP: begin
        if (w_better) begin
          w_best_nxt     = w_ram_rdata;
          w_best_idx_nxt = r_j;
        end
        if (r_j == C_LAST) begin
          w_state_nxt = SWAP_A;
        end else begin
          w_j_nxt     = r_j + C_ONE;
          w_ram_raddr = r_j + C_ONE;
          w_state_nxt = IN_WAIT;
        end
      end
      SWAP_A: begin
        w_ram_we    = (r_best_idx != r_i);
        w_ram_waddr = r_best_idx;
        w_ram_wdata = r_cur;
        w_state_nxt = SWAP_B;
      end
      SWAP_B: begin
        w_ram_we    = (r_best_idx != r_i);
        w_ram_waddr = r_i;
        w_ram_wdata = r_best;
        if (r_i == C_LAST_I) begin
          w_state_nxt = IDLE;
        end else begin
          w_i_nxt     = r_i + C_ONE;
          w_state_nxt = OUT_RD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

`ifdef SORTER_SWAP_COUNT_EN
  logic [ADDR_W-1:0] r_swap_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_swap_cnt <= '0;
    end else if (w_accept) begin
      r_swap_cnt <= '0;
    end else if (r_state == SWAP_A && r_best_idx != r_i) begin
      r_swap_cnt <= r_swap_cnt + C_ONE;
    end
  end

  assign swap_count = r_swap_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_param_sorter.sv
`default_nettype none

module tb_param_sorter;

  logic        clk    = 1'b0;
  logic        nrst   = 1'b0;
  logic        start  = 1'b0;
  logic        desc   = 1'b0;
  logic        wr     = 1'b0;
  logic [3:0]  addr   = '0;
  logic [15:0] datain = '0;
  int          sel    = 0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // DUT 0: 8x8 unsigned, 1: 8x8 signed, 2: 2x8 unsigned, 3: 16x16 unsigned
  int c_depth  [4] = '{8, 8, 2, 16};
  int c_width  [4] = '{8, 8, 8, 16};
  bit c_signed [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  logic [7:0]  d_a, d_s, d_2;
  logic [15:0] d_w;
  logic        rdy_a, rdy_s, rdy_2, rdy_w;
  logic [15:0] dout [4];
  logic        rdy  [4];

  assign dout[0] = {8'h00, d_a};
  assign dout[1] = {8'h00, d_s};
  assign dout[2] = {8'h00, d_2};
  assign dout[3] = d_w;
  assign rdy[0]  = rdy_a;
  assign rdy[1]  = rdy_s;
  assign rdy[2]  = rdy_2;
  assign rdy[3]  = rdy_w;

`ifdef SORTER_SWAP_COUNT_EN
  logic [2:0]  sc_a, sc_s;
  logic [0:0]  sc_2;
  logic [3:0]  sc_w;
  logic [15:0] scnt [4];
  assign scnt[0] = {13'd0, sc_a};
  assign scnt[1] = {13'd0, sc_s};
  assign scnt[2] = {15'd0, sc_2};
  assign scnt[3] = {12'd0, sc_w};
`endif

  param_sorter #(.DATA_W(8), .DEPTH(8), .SIGNED(0)) u_a (
    .clk(clk), .nrst(nrst), .start(start && sel == 0), .desc(desc),
    .wr(wr && sel == 0), .addr(addr[2:0]), .datain(datain[7:0]), .dataout(d_a),
`ifdef SORTER_SWAP_COUNT_EN
    .swap_count(sc_a),
`endif
    .ready(rdy_a));

  param_sorter #(.DATA_W(8), .DEPTH(8), .SIGNED(1)) u_s (
    .clk(clk), .nrst(nrst), .start(start && sel == 1), .desc(desc),
    .wr(wr && sel == 1), .addr(addr[2:0]), .datain(datain[7:0]), .dataout(d_s),
`ifdef SORTER_SWAP_COUNT_EN
    .swap_count(sc_s),
`endif
    .ready(rdy_s));

  param_sorter #(.DATA_W(8), .DEPTH(2), .SIGNED(0)) u_2 (
    .clk(clk), .nrst(nrst), .start(start && sel == 2), .desc(desc),
    .wr(wr && sel == 2), .addr(addr[0:0]), .datain(datain[7:0]), .dataout(d_2),
`ifdef SORTER_SWAP_COUNT_EN
    .swap_count(sc_2),
`endif
    .ready(rdy_2));

  param_sorter #(.DATA_W(16), .DEPTH(16), .SIGNED(0)) u_w (
    .clk(clk), .nrst(nrst), .start(start && sel == 3), .desc(desc),
    .wr(wr && sel == 3), .addr(addr), .datain(datain), .dataout(d_w),
`ifdef SORTER_SWAP_COUNT_EN
    .swap_count(sc_w),
`endif
    .ready(rdy_w));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] mm    [4][16];
  bit          mk    [4][16];
  logic [15:0] m_res [4][16];
  bit          m_res_ok [4];
  bit          m_busy [4];
  int          m_cnt  [4];
  logic [15:0] m_dout [4];
  bit          m_dk   [4];
  int          m_sc   [4];
  int          m_sc_pend [4];
  bit          m_live = 1'b0;

  function automatic int keyv(input logic [15:0] v, input int w, input bit s);
    int r;
    r = int'(v) & ((1 << w) - 1);
    if (s && v[w-1]) r = r - (1 << w);
    return r;
  endfunction

  function automatic int lat_of(input int d);
    return 4 * (d - 1) + d * (d - 1);
  endfunction

  // Final contents and number of effective exchanges of a selection sort
  task automatic model_sort(input int k, input bit d);
    logic [15:0] t [16];
    logic [15:0] tmp;
    int n, sc, bi;
    bit ok;
    n  = c_depth[k];
    ok = 1'b1;
    sc = 0;
    for (int a = 0; a < 16; a++) t[a] = mm[k][a];
    for (int a = 0; a < n; a++) if (!mk[k][a]) ok = 1'b0;
    for (int i = 0; i < n - 1; i++) begin
      bi = i;
      for (int j = i + 1; j < n; j++) begin
        if (d ? keyv(t[j], c_width[k], c_signed[k]) > keyv(t[bi], c_width[k], c_signed[k])
              : keyv(t[j], c_width[k], c_signed[k]) < keyv(t[bi], c_width[k], c_signed[k]))
          bi = j;
      end
      if (bi != i) begin
        tmp = t[i]; t[i] = t[bi]; t[bi] = tmp;
        sc++;
      end
    end
    for (int a = 0; a < 16; a++) m_res[k][a] = t[a];
    m_res_ok[k]  = ok;
    m_sc_pend[k] = sc;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      m_busy[k] = 1'b0; m_dk[k] = 1'b0; m_sc[k] = 0; m_dout[k] = '0;
      for (int a = 0; a < 16; a++) mk[k][a] = 1'b0;
    end
    forever begin
      @(posedge clk or negedge nrst);
      if (!nrst) begin
        for (int k = 0; k < 4; k++) begin
          if (m_busy[k]) for (int a = 0; a < 16; a++) mk[k][a] = 1'b0;
          m_busy[k] = 1'b0; m_dout[k] = '0; m_dk[k] = 1'b1; m_sc[k] = 0;
        end
        m_live = 1'b1;
      end else begin
        for (int k = 0; k < 4; k++) begin
          int a;
          a = int'(addr) % c_depth[k];
          if (m_busy[k]) begin
            m_cnt[k]++;
            if (m_cnt[k] == lat_of(c_depth[k])) begin
              m_busy[k] = 1'b0;
              for (int b = 0; b < c_depth[k]; b++) begin
                mm[k][b] = m_res[k][b];
                mk[k][b] = m_res_ok[k];
              end
              m_sc[k] = m_sc_pend[k];
            end
          end else if (start && sel == k) begin
            m_busy[k] = 1'b1;
            m_cnt[k]  = 0;
            m_sc[k]   = 0;
            model_sort(k, desc);
          end else begin
            m_dout[k] = mm[k][a];
            m_dk[k]   = mk[k][a];
            if (wr && sel == k) begin
              mm[k][a] = datain & 16'((1 << c_width[k]) - 1);
              mk[k][a] = 1'b1;
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("ready%0d", k), 32'(rdy[k]), 32'(!m_busy[k]));
          if (m_dk[k]) chk($sformatf("dataout%0d", k), 32'(dout[k]), 32'(m_dout[k]));
`ifdef SORTER_SWAP_COUNT_EN
          if (!m_busy[k]) chk($sformatf("swap_count%0d", k), 32'(scnt[k]), 32'(m_sc[k]));
`endif
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [15:0] vin  [$];
  logic [15:0] vexp [$];

  task automatic load(input int k);
    @(negedge clk);
    sel = k;
    for (int a = 0; a < vin.size(); a++) begin
      wr = 1'b1; addr = 4'(a); datain = vin[a];
      @(negedge clk);
    end
    wr = 1'b0;
  endtask

  // mode 0 plain, 1 wr/start pulses while busy, 2 wr with start, 3 reset at 30
  task automatic run_sort(input int k, input bit d, input int mode, output int n);
    @(negedge clk);
    sel = k; desc = d; start = 1'b1;
    if (mode == 2) begin
      wr = 1'b1; addr = 4'd0; datain = 16'h00AA;
    end
    @(negedge clk);
    start = 1'b0; wr = 1'b0; desc = ~d;
    n = 0;
    while (!rdy[k] && n < 2000) begin
      @(negedge clk);
      n++;
      if (mode == 1 && n == 10) begin
        wr = 1'b1; start = 1'b1; addr = 4'd0; datain = 16'h00AA;
      end
      if (mode == 1 && n == 11) begin
        wr = 1'b0; start = 1'b0;
      end
      if (mode == 3 && n == 30) begin
        #2 nrst = 1'b0;
        #1;
        chk("reset_ready", 32'(rdy[k]), 32'd1);
        chk("reset_dataout", 32'(dout[k]), 32'd0);
        @(negedge clk);
        #2 nrst = 1'b1;
        return;
      end
    end
    if (n >= 2000) chk("ready_timeout", 32'(n), 32'd0);
  endtask

  task automatic rd_chk(input int k, input string nm);
    for (int a = 0; a < vexp.size(); a++) begin
      @(negedge clk);
      sel = k; wr = 1'b0; addr = 4'(a);
      @(negedge clk);
      chk($sformatf("%s[%0d]", nm, a), 32'(dout[k]), 32'(vexp[a]));
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(rdy[0]), 32'd1);
    chk("reset_dataout", 32'(dout[0]), 32'd0);

    // basic ascending
    vin = '{16'd5, 16'd3, 16'd7, 16'd1, 16'd8, 16'd2, 16'd6, 16'd4};
    load(0);
    run_sort(0, 1'b0, 0, n);
    chk("latency_asc", 32'(n), 32'd84);
`ifdef SORTER_SWAP_COUNT_EN
    chk("swap_count_asc", 32'(scnt[0]), 32'd6);
`endif
    vexp = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    rd_chk(0, "asc");

    // descending
    load(0);
    run_sort(0, 1'b1, 0, n);
    chk("latency_desc", 32'(n), 32'd84);
    vexp = '{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    rd_chk(0, "desc");

    // signed vs unsigned compare
    vin = '{16'h80, 16'h7F, 16'h00, 16'hFF, 16'h01, 16'hFE, 16'h10, 16'hF0};
    load(1);
    run_sort(1, 1'b0, 0, n);
    vexp = '{16'h80, 16'hF0, 16'hFE, 16'hFF, 16'h00, 16'h01, 16'h10, 16'h7F};
    rd_chk(1, "signed");
    load(0);
    run_sort(0, 1'b0, 0, n);
    vexp = '{16'h00, 16'h01, 16'h10, 16'h7F, 16'h80, 16'hF0, 16'hFE, 16'hFF};
    rd_chk(0, "unsigned");

    // all equal and already sorted
    vin = '{16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9};
    load(0);
    run_sort(0, 1'b0, 0, n);
    chk("latency_equal", 32'(n), 32'd84);
`ifdef SORTER_SWAP_COUNT_EN
    chk("swap_count_equal", 32'(scnt[0]), 32'd0);
`endif
    vexp = vin;
    rd_chk(0, "equal");
    vin = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    load(0);
    run_sort(0, 1'b0, 0, n);
    chk("latency_sorted", 32'(n), 32'd84);
`ifdef SORTER_SWAP_COUNT_EN
    chk("swap_count_sorted", 32'(scnt[0]), 32'd0);
`endif
    vexp = vin;
    rd_chk(0, "sorted");

    // host activity while busy, then start+wr in the same idle cycle
    vin = '{16'd5, 16'd3, 16'd7, 16'd1, 16'd8, 16'd2, 16'd6, 16'd4};
    vexp = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    load(0);
    run_sort(0, 1'b0, 1, n);
    chk("latency_busy_poke", 32'(n), 32'd84);
    rd_chk(0, "busy_poke");
    load(0);
    run_sort(0, 1'b0, 2, n);
    rd_chk(0, "start_wr");

    // reset mid-sort, then a clean reload
    load(0);
    run_sort(0, 1'b0, 3, n);
    load(0);
    run_sort(0, 1'b0, 0, n);
    chk("latency_after_reset", 32'(n), 32'd84);
    rd_chk(0, "after_reset");

    // DEPTH=2
    vin = '{16'd2, 16'd1};
    load(2);
    run_sort(2, 1'b0, 0, n);
    chk("latency_d2", 32'(n), 32'd6);
    vexp = '{16'd1, 16'd2};
    rd_chk(2, "d2");

    // DATA_W=16, DEPTH=16 with a duplicate value
    vin = '{16'h1000, 16'hFFFF, 16'h0003, 16'h8000, 16'h0042, 16'h7FFF, 16'h0001, 16'hABCD,
            16'h0100, 16'h0000, 16'hFFFE, 16'h2222, 16'h0042, 16'h0010, 16'hC000, 16'h0005};
    load(3);
    run_sort(3, 1'b0, 0, n);
    chk("latency_w16", 32'(n), 32'd300);
    vexp = '{16'h0000, 16'h0001, 16'h0003, 16'h0005, 16'h0010, 16'h0042, 16'h0042, 16'h0100,
             16'h1000, 16'h2222, 16'h7FFF, 16'h8000, 16'hABCD, 16'hC000, 16'hFFFE, 16'hFFFF};
    rd_chk(3, "w16");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/param_sorter.md
Name: param_sorter

Overview:
- In-place selection sorter over an internal DEPTH x DATA_W single-clock RAM.
- Parametrised successor of the fixed 8x8-bit sorter: adds width/depth parameters, a runtime ascending/descending mode, signed compare, deterministic latency and explicit host-port arbitration.
- Host loads data through a write port, pulses start, waits for ready, then reads the sorted data back.
- Sits as a memory-mapped accelerator beside the lab CPU/testbench bus.

Parameters:
- DATA_W, 8, element width in bits.
- DEPTH, 8, element count; power of two, >= 2.
- ADDR_W, $clog2(DEPTH), address width; derived, never overridden.
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned.

Ports:
- clk  in  1  single clock, all state on posedge.
- nrst  in  1  asynchronous active-low reset.
- start  in  1  begin sort; sampled only while ready=1.
- desc  in  1  0 = ascending, 1 = descending; latched when start is accepted.
- wr  in  1  host write strobe; honoured only while ready=1.
- addr  in  ADDR_W  host read/write address.
- datain  in  DATA_W  host write data.
- dataout  out  DATA_W  host read data, registered.
- ready  out  1  1 = idle, host owns memory.

Behaviour:
- Reset (async, nrst=0): state IDLE, ready=1, dataout=0, all counters 0. Memory contents are not cleared. Reset mid-sort aborts and leaves memory partially sorted.
- IDLE, host access:
  - wr=1: mem[addr] <= datain at the edge.
  - wr=0: dataout <= mem[addr] at the edge (1-cycle read latency).
  - wr=1 and same-cycle read of the same addr: dataout gets the old data.
- start=1 in IDLE:
  - Sort is accepted and desc is latched.
  - Takes priority over wr in the same cycle; that write is dropped.
  - ready=0 from the next edge.
- Busy: start, wr, addr and desc are ignored; dataout holds its last value.
- Algorithm: for i = 0..DEPTH-2, find the extreme of mem[i..DEPTH-1], then swap it into i.
- Compare:
  - Ascending: replace the best only if cand < best (strict). Descending: only if cand > best (strict).
  - Ties keep the earliest index, so equal values are never swapped.
  - Width DATA_W; signedness per SIGNED.
- States and cycles:
  - OUT_RD (1 cycle): issue read mem[i].
  - OUT_WAIT (1 cycle): best <= data, cur <= data, best_idx <= i, j <= i+1, issue read mem[j].
  - IN_WAIT (1 cycle): wait for read data.
  - IN_CMP (1 cycle): compare and update best/best_idx. If j == DEPTH-1 go to SWAP_A; else j <= j+1, issue read, go to IN_WAIT.
  - SWAP_A (1 cycle): mem[best_idx] <= cur.
  - SWAP_B (1 cycle): mem[i] <= best. Then if i == DEPTH-2 go to IDLE with ready=1; else i <= i+1 and go to OUT_RD.
  - When best_idx == i, both swap writes are suppressed but both cycles are still spent.
- Latency: fixed 4(DEPTH-1) + DEPTH(DEPTH-1) cycles from the start-accept edge to the ready=1 edge. DEPTH=8 gives 84; DEPTH=2 gives 6.
- Index arithmetic is ADDR_W bits wide; i and j never wrap because loop bounds are checked before increment.

Optional Feature:
- Macro SORTER_SWAP_COUNT_EN.
- Defined: adds output swap_count (ADDR_W bits).
  - Cleared to 0 on start accept and on reset.
  - Increments in each SWAP_A where best_idx != i.
  - Holds its value in IDLE; maximum DEPTH-1.
- Undefined: port and counter are absent; the rest of the behaviour is identical.

Decomposition:
- Package sorter_pkg holds:
  - state enum (IDLE, OUT_RD, OUT_WAIT, IN_WAIT, IN_CMP, SWAP_A, SWAP_B);
  - a latency function of DEPTH;
  - a compare function (a, b, desc, signed).
- One sub-module, sorter_ram: parameters DATA_W/DEPTH, one write port and one registered read port, no reset on the array.
- Muxing of host vs FSM onto the RAM ports lives in param_sorter.

Test Plan:
- Load 8-bit {5,3,7,1,8,2,6,4}, ascending, start -> ready after exactly 84 cycles; readback {1,2,3,4,5,6,7,8}; swap_count=6 if enabled.
- Same data, desc=1 -> readback {8,7,6,5,4,3,2,1}.
- SIGNED=1, data {8'h80,8'h7F,8'h00,8'hFF,...}, ascending -> -128 first, 127 last. SIGNED=0 with the same data -> 8'h00 first, 8'hFF last.
- All-equal {9,...}, and already-sorted input -> contents unchanged, latency still 84, swap_count=0.
- During the sort, pulse wr to addr 0 with 8'hAA and re-pulse start -> both ignored, result unaffected. start and wr in the same idle cycle -> write dropped.
- Assert nrst low at cycle 30 of a sort -> ready=1 and dataout=0 immediately; a new load and sort afterwards is correct. Also run DEPTH=2 ({2,1} -> {1,2} in 6 cycles) and DATA_W=16, DEPTH=16.
